// File: rtl/emc_reg_bridge.sv
// Bridge from an asynchronous 16-bit EMC bus to a synchronous register-file port.
// Adds channel-window decode and paired 16-bit writes that form 32-bit queue entries.
module emc_reg_bridge #(
    parameter int unsigned AW      = 8,
    parameter int unsigned NCH     = 4,
    parameter int unsigned CH_BASE = 'h80,
    parameter int unsigned CH_LOG2 = 5,
    parameter int unsigned Q32_OFF = 'h0c,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:1]   A_i,
    input  logic [15:0]     d_i,
    output logic [15:0]     d_o,
    output logic            d_oe_o,
    input  logic            CSN_i,
    input  logic            WEN_i,
    input  logic            OEN_i,
    output logic [AW-1:0]   reg_addr_o,
    output logic [31:0]     reg_wdat_o,
    output logic            reg_wr_o,
    output logic            reg_wr32_o,
    output logic            reg_rd_o,
    input  logic [15:0]     reg_rdat_i,
    output logic [NCH-1:0]  ch_sel_o,
    output logic            core_sel_o,
    output logic            seq_err_o
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StHold} state_e;

    state_e state_q, state_d;

    logic csn_s1_q, csn_s2_q, wen_s1_q, wen_s2_q, wen_s3_q, oen_s1_q, oen_s2_q;
    logic armed_q;
    logic wen_rise;

    logic [AW-1:1] sh_a_q;
    logic [15:0]   sh_d_q;

    logic commit_set, rd_start, in_read;
    logic commit_q;

    logic           pend_q;
    logic [NCH-1:0] pend_ch_q;
    logic [15:0]    lo_q;

    logic [AW-1:0]  reg_addr_q;
    logic [31:0]    reg_wdat_q;
    logic           reg_wr_q, reg_wr32_q, reg_rd_q, seq_err_q;
    logic [NCH-1:0] ch_sel_q;
    logic           core_sel_q;

    logic           rd_pend_q;
    logic [1:0]     rd_cnt_q;
    logic           rd_capture;
    logic           oe_q;
    logic [15:0]    d_q;

    logic [AW-1:0]  wr_addr, rd_addr;
    logic [NCH-1:0] wr_ch, rd_ch;
    logic           wr_in_win, wr_lo, wr_hi;

    function automatic logic [NCH-1:0] ch_decode(input logic [AW-1:0] addr);
        logic [NCH-1:0] sel;
        logic [31:0]    a;
        a   = 32'(addr);
        sel = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            sel[k] = (a >= CH_BASE + (k << CH_LOG2)) && (a < CH_BASE + ((k + 1) << CH_LOG2));
        end
        return sel;
    endfunction

    assign wen_rise = wen_s2_q & ~wen_s3_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            csn_s1_q <= 1'b0;
            csn_s2_q <= 1'b0;
            wen_s1_q <= 1'b0;
            wen_s2_q <= 1'b0;
            wen_s3_q <= 1'b0;
            oen_s1_q <= 1'b0;
            oen_s2_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            csn_s1_q <= CSN_i;
            csn_s2_q <= csn_s1_q;
            wen_s1_q <= WEN_i;
            wen_s2_q <= wen_s1_q;
            wen_s3_q <= wen_s2_q;
            oen_s1_q <= OEN_i;
            oen_s2_q <= oen_s1_q;
            // A cycle already under way at reset release is ignored until CSN is seen high.
            if (csn_s2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sh_a_q <= '0;
            sh_d_q <= '0;
        end else if (!wen_s1_q && !csn_s1_q) begin
            sh_a_q <= A_i;
            sh_d_q <= d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (armed_q && !csn_s2_q) begin
                    if (!wen_s2_q) begin
                        state_d = StWrite;
                    end else if (!oen_s2_q) begin
                        state_d = StRead;
                    end
                end
            end
            StWrite: begin
                if (wen_rise) begin
                    state_d = StHold;
                end else if (csn_s2_q) begin
                    state_d = StIdle;
                end
            end
            StRead: begin
                if (oen_s2_q || csn_s2_q) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (csn_s2_q || !wen_s2_q || !oen_s2_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        commit_set = 1'b0;
        rd_start   = 1'b0;
        in_read    = 1'b0;
        unique case (state_q)
            StIdle:  rd_start   = (state_d == StRead);
            StWrite: commit_set = wen_rise;
            StRead:  in_read    = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        wr_addr   = {sh_a_q, 1'b0};
        rd_addr   = {A_i, 1'b0};
        wr_ch     = ch_decode(wr_addr);
        rd_ch     = ch_decode(rd_addr);
        wr_in_win = |wr_ch;
        wr_lo     = wr_in_win && (wr_addr[CH_LOG2-1:0] == CH_LOG2'(Q32_OFF));
        wr_hi     = wr_in_win && (wr_addr[CH_LOG2-1:0] == CH_LOG2'(Q32_OFF + 2));
    end

    assign rd_capture = (reg_rd_q && (RD_LAT == 0)) || (rd_pend_q && (rd_cnt_q == 2'd0));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            commit_q   <= 1'b0;
            pend_q     <= 1'b0;
            pend_ch_q  <= '0;
            lo_q       <= '0;
            reg_addr_q <= '0;
            reg_wdat_q <= '0;
            reg_wr_q   <= 1'b0;
            reg_wr32_q <= 1'b0;
            reg_rd_q   <= 1'b0;
            seq_err_q  <= 1'b0;
            ch_sel_q   <= '0;
            core_sel_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_cnt_q   <= '0;
            oe_q       <= 1'b0;
            d_q        <= '0;
        end else begin
            commit_q   <= commit_set;
            reg_wr_q   <= 1'b0;
            reg_wr32_q <= 1'b0;
            reg_rd_q   <= 1'b0;
            seq_err_q  <= 1'b0;
            if (commit_q) begin
                reg_addr_q <= wr_addr;
                ch_sel_q   <= wr_ch;
                core_sel_q <= ~wr_in_win;
                if (pend_q && wr_hi && (pend_ch_q == wr_ch)) begin
                    reg_wr32_q <= 1'b1;
                    reg_wdat_q <= {sh_d_q, lo_q};
                    pend_q     <= 1'b0;
                end else if (wr_lo) begin
                    // A fresh low word replaces an orphaned one.
                    seq_err_q  <= pend_q;
                    lo_q       <= sh_d_q;
                    pend_q     <= 1'b1;
                    pend_ch_q  <= wr_ch;
                end else begin
                    reg_wr_q   <= 1'b1;
                    reg_wdat_q <= {16'h0000, sh_d_q};
                    seq_err_q  <= pend_q;
                    pend_q     <= 1'b0;
                end
            end else if (rd_start) begin
                reg_rd_q   <= 1'b1;
                reg_addr_q <= rd_addr;
                ch_sel_q   <= rd_ch;
                core_sel_q <= ~|rd_ch;
            end

            if (reg_rd_q && (RD_LAT != 0)) begin
                rd_pend_q <= 1'b1;
                rd_cnt_q  <= 2'(RD_LAT - 1);
            end else if (rd_pend_q) begin
                if (rd_cnt_q == 2'd0) begin
                    rd_pend_q <= 1'b0;
                end else begin
                    rd_cnt_q <= rd_cnt_q - 2'd1;
                end
            end

            if (!in_read) begin
                oe_q <= 1'b0;
            end else if (rd_capture) begin
                oe_q <= 1'b1;
                d_q  <= reg_rdat_i;
            end
        end
    end

    // Output enable drops as soon as the synchronized strobes show the read is over.
    assign d_oe_o     = oe_q & ~oen_s2_q & ~csn_s2_q;
    assign d_o        = d_q;
    assign reg_addr_o = reg_addr_q;
    assign reg_wdat_o = reg_wdat_q;
    assign reg_wr_o   = reg_wr_q;
    assign reg_wr32_o = reg_wr32_q;
    assign reg_rd_o   = reg_rd_q;
    assign ch_sel_o   = ch_sel_q;
    assign core_sel_o = core_sel_q;
    assign seq_err_o  = seq_err_q;

endmodule

// File: tb/tb_emc_reg_bridge.sv
// Randomized bench for emc_reg_bridge: transaction-level reference model with a
// per-cycle compare process, plus directed cases with literal expectations.
module tb_emc_reg_bridge;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:1]  a = '0;
    logic [15:0] din = '0;
    logic        csn = 1'b1, wen = 1'b1, oen = 1'b1;
    logic [15:0] rdat = '0;

    logic [15:0] dout;
    logic        doe;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdat;
    logic        reg_wr, reg_wr32, reg_rd, core_sel, seq_err;
    logic [3:0]  ch_sel;

    logic [15:0] d2_dout;
    logic        d2_doe;
    logic [7:0]  d2_addr;
    logic [31:0] d2_wdat;
    logic        d2_wr, d2_wr32, d2_rd, d2_core, d2_err;
    logic [1:0]  d2_ch;

    always #5 clk = ~clk;

    emc_reg_bridge #(.NCH(NCH)) dut (
        .clk_i(clk), .rst_i(rst), .A_i(a), .d_i(din), .d_o(dout), .d_oe_o(doe),
        .CSN_i(csn), .WEN_i(wen), .OEN_i(oen), .reg_addr_o(reg_addr), .reg_wdat_o(reg_wdat),
        .reg_wr_o(reg_wr), .reg_wr32_o(reg_wr32), .reg_rd_o(reg_rd), .reg_rdat_i(rdat),
        .ch_sel_o(ch_sel), .core_sel_o(core_sel), .seq_err_o(seq_err)
    );

    emc_reg_bridge #(.NCH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .A_i(a), .d_i(din), .d_o(d2_dout), .d_oe_o(d2_doe),
        .CSN_i(csn), .WEN_i(wen), .OEN_i(oen), .reg_addr_o(d2_addr), .reg_wdat_o(d2_wdat),
        .reg_wr_o(d2_wr), .reg_wr32_o(d2_wr32), .reg_rd_o(d2_rd), .reg_rdat_i(rdat),
        .ch_sel_o(d2_ch), .core_sel_o(d2_core), .seq_err_o(d2_err)
    );

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: data valid exactly one cycle after the read strobe, junk otherwise.
    logic [15:0] mem [256];
    always @(posedge clk) rdat <= reg_rd ? mem[reg_addr] : 16'($urandom);

    // Reference model state
    bit          pend = 1'b0;
    int          pend_ch = 0;
    logic [15:0] lo = '0;
    logic [2:0]  ex_stb [int];   // {wr, wr32, seq_err}
    logic [7:0]  ex_addr [int];
    logic [31:0] ex_wdat [int];
    logic [3:0]  ex_ch [int];
    logic        ex_core [int];

    bit          rd_active = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [15:0] rd_data = '0;
    int          rd_seen = 0;
    bit          oe_seen = 1'b0;

    logic [7:0]  last_addr = '0;
    logic [31:0] last_wdat = '0;
    logic [3:0]  last_ch = '0, last_rd_ch = '0;
    logic        last_core = 1'b0, last_err_wr = 1'b0;
    int          n_wr = 0, n_wr32 = 0;
    int          chk2_key = -1;
    logic [2:0]  es;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int ch_of(input int addr);
        if (addr >= 'h80 && addr < 'h80 + NCH * 32) return (addr - 'h80) / 32;
        return -1;
    endfunction

    function automatic void model_write(input int addr, input logic [15:0] data, input int key);
        int ch;
        int off;
        ch = ch_of(addr);
        off = addr % 32;
        ex_addr[key] = 8'(addr);
        ex_ch[key]   = (ch >= 0) ? 4'(1 << ch) : 4'b0000;
        ex_core[key] = (ch < 0);
        if (ch >= 0 && off == 14 && pend && pend_ch == ch) begin
            ex_stb[key]  = 3'b010;
            ex_wdat[key] = {data, lo};
            pend = 1'b0;
        end else if (ch >= 0 && off == 12) begin
            ex_stb[key] = {2'b00, pend};
            lo = data;
            pend = 1'b1;
            pend_ch = ch;
        end else begin
            ex_stb[key]  = {2'b10, pend};
            ex_wdat[key] = {16'h0000, data};
            pend = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            es = ex_stb.exists(cyc) ? ex_stb[cyc] : 3'b000;
            check("strobes", {29'b0, reg_wr, reg_wr32, seq_err}, {29'b0, es});
            if (es[2] || es[1]) begin
                check("wr_addr", reg_addr, ex_addr[cyc]);
                check("wr_data", reg_wdat, ex_wdat[cyc]);
                check("wr_ch", ch_sel, ex_ch[cyc]);
                check("wr_core", core_sel, ex_core[cyc]);
            end
            if (reg_wr || reg_wr32) begin
                last_addr = reg_addr;
                last_wdat = reg_wdat;
                last_ch = ch_sel;
                last_core = core_sel;
                last_err_wr = seq_err & reg_wr;
                n_wr += int'(reg_wr);
                n_wr32 += int'(reg_wr32);
            end
            check("one_strobe", {31'b0, ($countones({reg_wr, reg_wr32, reg_rd}) > 1)}, 0);
            if (reg_rd) begin
                check("rd_expected", {31'b0, (rd_active && rd_seen == 0)}, 1);
                check("rd_addr", reg_addr, rd_addr);
                check("rd_ch", ch_sel, (ch_of(rd_addr) >= 0) ? 4'(1 << ch_of(rd_addr)) : 4'b0);
                check("rd_core", core_sel, ch_of(rd_addr) < 0);
                last_rd_ch = ch_sel;
                rd_seen++;
            end
            if (doe) begin
                check("oe_in_read", rd_active, 1);
                if (rd_active) check("rd_dout", dout, rd_data);
                oe_seen = 1'b1;
            end
            if (cyc == chk2_key) begin
                check("nch2_wr", d2_wr, 1);
                check("nch2_core", d2_core, 1);
                check("nch2_ch", d2_ch, 2'b00);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic emc_write(input int addr, input logic [15:0] data, input bit with_oen,
                             input bit chk2);
        int key;
        @(negedge clk);
        csn = 1'b0;
        a = 7'(addr >> 1);
        din = data;
        idle($urandom_range(0, 2));
        wen = 1'b0;
        if (with_oen) oen = 1'b0;
        idle($urandom_range(3, 6));
        wen = 1'b1;
        oen = 1'b1;
        // First edge after this point samples WEN high; commit lands three edges later.
        key = cyc + 4;
        model_write(addr, data, key);
        if (chk2) chk2_key = key;
        idle($urandom_range(1, 3));
        csn = 1'b1;
        idle(1);
        din = 16'($urandom);
        a = 7'($urandom);
        idle($urandom_range(3, 5));
    endtask

    task automatic emc_read(input int addr);
        rd_addr = 8'(addr);
        rd_data = mem[addr];
        rd_seen = 0;
        oe_seen = 1'b0;
        rd_active = 1'b1;
        @(negedge clk);
        csn = 1'b0;
        a = 7'(addr >> 1);
        idle($urandom_range(0, 2));
        oen = 1'b0;
        idle($urandom_range(8, 12));
        oen = 1'b1;
        idle(3);
        check("rd_oe_drop", doe, 0);
        check("rd_count", rd_seen, 1);
        check("rd_oe_seen", oe_seen, 1);
        rd_active = 1'b0;
        csn = 1'b1;
        idle($urandom_range(3, 5));
    endtask

    task automatic emc_abort(input int addr);
        @(negedge clk);
        csn = 1'b0;
        a = 7'(addr >> 1);
        din = 16'($urandom);
        wen = 1'b0;
        idle(4);
        csn = 1'b1;
        idle(3);
        wen = 1'b1;
        idle(4);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_doe"}, doe, 0);
        check({tag, "_addr"}, reg_addr, 0);
        check({tag, "_wdat"}, reg_wdat, 0);
        check({tag, "_strb"}, {reg_wr, reg_wr32, reg_rd, seq_err}, 0);
        check({tag, "_sel"}, {ch_sel, core_sel}, 0);
    endtask

    initial begin
        int n0, n32, addr, r, s, ch;
        bit got;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem['hc2] = 16'ha55a;

        rst = 1'b0;
        idle(4);
        check_all_zero("reset");
        rst = 1'b1;
        idle(4);
        mon_on = 1'b1;

        // Plain core write
        n0 = n_wr;
        emc_write('h04, 16'hfedc, 1'b0, 1'b0);
        check("t1_nwr", n_wr - n0, 1);
        check("t1_addr", last_addr, 8'h04);
        check("t1_wdat", last_wdat, 32'h0000fedc);
        check("t1_core", last_core, 1);
        check("t1_ch", last_ch, 4'b0000);

        // Paired queue write on channel 0
        n0 = n_wr;
        n32 = n_wr32;
        emc_write('h8c, 16'h5678, 1'b0, 1'b0);
        emc_write('h8e, 16'h1234, 1'b0, 1'b0);
        check("t2_nwr32", n_wr32 - n32, 1);
        check("t2_nwr", n_wr - n0, 0);
        check("t2_wdat", last_wdat, 32'h12345678);
        check("t2_ch", last_ch, 4'b0001);

        // Read in channel 2 window
        emc_read('hc2);
        check("t3_dout", dout, 16'ha55a);
        check("t3_ch", last_rd_ch, 4'b0100);

        // Orphaned low word
        n32 = n_wr32;
        emc_write('h8c, 16'h0bad, 1'b0, 1'b0);
        emc_write('h04, 16'h1111, 1'b0, 1'b0);
        check("t4_err_with_wr", last_err_wr, 1);
        check("t4_addr", last_addr, 8'h04);
        check("t4_nwr32", n_wr32 - n32, 0);

        // WEN and OEN low together resolve as a write
        n0 = n_wr;
        emc_write('h10, 16'hbeef, 1'b1, 1'b0);
        check("t5_nwr", n_wr - n0, 1);

        // CSN rising before WEN aborts with no strobe
        n0 = n_wr;
        emc_abort('h20);
        check("t6_nwr", n_wr - n0, 0);

        // Narrower instance sees 0xc0 as a core address
        emc_write('hc0, 16'h4242, 1'b0, 1'b1);

        // Reset during the driven phase of a read
        rd_addr = 8'ha6;
        rd_data = mem['ha6];
        rd_seen = 0;
        rd_active = 1'b1;
        @(negedge clk);
        csn = 1'b0;
        a = 7'('ha6 >> 1);
        oen = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = doe;
        end
        check("t8_oe_seen", got, 1);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("t8_rst");
        rd_active = 1'b0;
        pend = 1'b0;
        rst = 1'b1;
        idle(6);
        check("t8_no_restrobe", rd_seen, 1);
        oen = 1'b1;
        csn = 1'b1;
        idle(4);
        emc_read('h5a);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                s = $urandom_range(0, 3);
                ch = $urandom_range(0, NCH - 1);
                if (s == 0) addr = 'h80 + ch * 32 + 12;
                else if (s == 1) addr = (pend && $urandom_range(0, 1) == 1) ?
                                        'h80 + pend_ch * 32 + 14 : 'h80 + ch * 32 + 14;
                else addr = $urandom_range(0, 127) * 2;
                emc_write(addr, 16'($urandom), r == 5, 1'b0);
            end else if (r < 9) begin
                emc_read($urandom_range(0, 127) * 2);
            end else begin
                emc_abort($urandom_range(0, 127) * 2);
            end
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/emc_reg_bridge.md
EMC_REG_BRIDGE -- requirements
Module: emc_reg_bridge

Interface
REQ-001 SHALL have parameter AW, default 8: EMC byte-address width; A[0] is unused.
REQ-002 SHALL have parameter NCH, default 4: number of timing-generator channel windows, range 1..8.
REQ-003 SHALL have parameter CH_BASE, default 8'h80: byte address of channel 0 window.
REQ-004 SHALL have parameter CH_LOG2, default 5: log2 of window size in bytes, so windows sit at 0x80/0xa0/0xc0/0xe0.
REQ-005 SHALL have parameter Q32_OFF, default 5'h0c: even byte offset of the 32-bit queue low word within each window.
REQ-006 SHALL have parameter RD_LAT, default 1: clk_i cycles from reg_rd_o to reg_rdat_i valid, range 0..3.
REQ-007 SHALL have ports, listed as name, direction, width, meaning:
- clk_i  in  1  single clock; every flop is on its rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- A_i  in  AW-1  EMC address bits [AW-1:1].
- d_i  in  16  EMC data in.
- d_o  out  16  EMC read data.
- d_oe_o  out  1  data-bus output enable.
- CSN_i / WEN_i / OEN_i  in  1 each  EMC strobes, asynchronous, active-low.
- reg_addr_o  out  AW  committed byte address, bit0 = 0.
- reg_wdat_o  out  32  write data: bits [15:0] for 16-bit writes; {hi,lo} for 32-bit writes.
- reg_wr_o  out  1  one-cycle 16-bit write strobe.
- reg_wr32_o  out  1  one-cycle 32-bit queue write strobe.
- reg_rd_o  out  1  one-cycle read strobe.
- reg_rdat_i  in  16  read data from the register file.
- ch_sel_o  out  NCH  one-hot channel select, valid with any strobe.
- core_sel_o  out  1  address lies outside every channel window.
- seq_err_o  out  1  one-cycle pulse on an orphaned 32-bit low word.

Function
REQ-008 SHALL pass CSN_i, WEN_i and OEN_i each through a 2-flop synchronizer; all edge detection SHALL use the synchronized signals.
REQ-009 SHALL load A_i and d_i into shadow registers on every cycle in which the first WEN_i sync stage is low and CSN_i's first stage is low.
REQ-010 SHALL use FSM states IDLE, WRITE, READ and HOLD.
- IDLE -> WRITE on synchronized CSN low with WEN low.
- IDLE -> READ on synchronized CSN low with OEN low.
- WRITE -> HOLD on the synchronized WEN rising edge.
- READ -> HOLD on synchronized OEN or CSN going high.
- HOLD -> IDLE on synchronized CSN high, or on WEN/OEN low for back-to-back cycles with CSN held low.
REQ-011 SHALL commit a write exactly 3 clk_i cycles after the first clk_i edge that samples WEN_i high, using the shadow values.
REQ-012 SHALL decode a write as channel k when CH_BASE + k*2^CH_LOG2 <= addr < CH_BASE + (k+1)*2^CH_LOG2 for k < NCH; any other address SHALL assert core_sel_o.
REQ-013 SHALL handle a write to offset Q32_OFF of any channel by latching the low word and setting pend with channel k, without asserting reg_wr_o.
REQ-014 SHALL handle a write to offset Q32_OFF+2 of the same channel while pend is set by asserting reg_wr32_o for 1 cycle with reg_wdat_o = {d, lo}, then clearing pend.
REQ-015 SHALL treat any other write while pend is set as follows: assert seq_err_o, clear pend, and commit that write normally in the same cycle.
REQ-016 SHALL treat a high-word write arriving with pend clear as an ordinary 16-bit write.
REQ-017 SHALL handle all other writes by asserting reg_wr_o for 1 cycle, with reg_wdat_o[31:16] = 0.
REQ-018 SHALL, on a read, assert reg_rd_o for exactly 1 cycle on READ entry, with reg_addr_o = A_i sampled at that cycle.
REQ-019 SHALL capture reg_rdat_i RD_LAT cycles after reg_rd_o into d_o and assert d_oe_o in that same cycle.
REQ-020 SHALL deassert d_oe_o in the first cycle synchronized OEN or CSN is high; d_o SHALL then hold its value.
REQ-021 SHALL never assert reg_wr_o, reg_wr32_o or reg_rd_o in the same cycle as one another.
REQ-022 SHALL resolve simultaneous synchronized WEN and OEN low in IDLE as a write, with no read strobe.
REQ-023 SHALL, on CSN going high in WRITE before any WEN rise, return to IDLE with no strobe.

Reset
REQ-024 SHALL, while rst_i is low at a clk_i edge, drive every output to 0, put the FSM in IDLE, clear pend and clear all synchronizers.
REQ-025 SHALL, on reset asserted mid-transaction, drop d_oe_o on the following cycle and discard the transaction.
REQ-026 SHALL, after rst_i goes high, ignore an EMC cycle already in progress until CSN has been seen high.

Verification
REQ-027 SHALL pass: write 16'hfedc to 0x04 -> one reg_wr_o pulse, reg_addr_o=0x04, reg_wdat_o=0x0000fedc, core_sel_o=1, ch_sel_o=0.
REQ-028 SHALL pass: write 0x5678 to 0x8c, then 0x1234 to 0x8e -> one reg_wr32_o pulse, reg_wdat_o=0x12345678, ch_sel_o=4'b0001, no reg_wr_o.
REQ-029 SHALL pass: read 0xc2 with reg_rdat_i=16'ha55a, RD_LAT=1 -> one reg_rd_o pulse, ch_sel_o=4'b0100, d_o=0xa55a with d_oe_o=1 until OEN rises, then d_oe_o=0 within 3 cycles.
REQ-030 SHALL pass: write 0x8c, then write 0x04 -> seq_err_o pulse together with reg_wr_o at 0x04, and no reg_wr32_o.
REQ-031 SHALL pass: rst_i low during the driven phase of a read -> d_oe_o=0 on the next cycle, and no strobes until the next full EMC cycle.
REQ-032 SHALL pass: with NCH=2, write to 0xc0 -> core_sel_o=1, ch_sel_o=2'b00, reg_wr_o pulse.
